// File: rtl/dense_argmax_pkg.sv
// Purpose : shared FSM encoding, fp32 constants and fp32 helpers for the argmax stage.
// Latency : n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dense_argmax_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] FP32_EXP_MASK = 32'h7F80_0000;
    localparam logic [31:0] FP32_MAN_MASK = 32'h007F_FFFF;

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return ((x & FP32_EXP_MASK) == FP32_EXP_MASK) && ((x & FP32_MAN_MASK) != 32'h0);
    endfunction

    // Maps an fp32 pattern onto an unsigned key whose integer order matches
    // the float order. -0 is folded onto +0 first so the two zeros tie.
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        logic [31:0] n;
        n = (x == FP32_NEG_ZERO) ? 32'h0 : x;
        return n[31] ? ~n : (n ^ FP32_NEG_ZERO);
    endfunction

endpackage

// File: rtl/dense_argmax_fp32_greater.sv
// Purpose : combinational fp32 "a strictly greater than b" test with NaN handling.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports   : a, b - fp32 operands; gt - 1 when a > b. A NaN a is never greater;
//           any non-NaN a beats a NaN b; +0 and -0 compare equal.
import dense_argmax_pkg::*;

module fp32_greater (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);

    logic a_nan;
    logic b_nan;

    assign a_nan = fp32_is_nan(a);
    assign b_nan = fp32_is_nan(b);
    assign gt    = !a_nan && (b_nan || (fp32_key(a) > fp32_key(b)));

endmodule

// File: rtl/dense_argmax.sv
// Purpose : sequential argmax over NUM_CLASSES fp32 dense outputs, one element per clock.
// Latency : done_o pulses after NUM_CLASSES rising edges counting the start-sampling edge.
// Backpressure: none; start_i is ignored while busy_o is high (no queueing).
// Ports   : clk, rst_n (async, active low); start_i request; data_i packed vector
//           (element k at [k*DATA_WIDTH +: DATA_WIDTH]); busy_o high during the scan;
//           done_o one-cycle result strobe; class_o / max_o winning index and value.
import dense_argmax_pkg::*;

module dense_argmax #(
    parameter int NUM_CLASSES = 128,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [DATA_WIDTH*NUM_CLASSES-1:0] data_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [IDX_W-1:0]                  class_o,
    output logic [DATA_WIDTH-1:0]             max_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_e                            state_q, state_d;
    logic [DATA_WIDTH*NUM_CLASSES-1:0] vec_q, vec_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [DATA_WIDTH-1:0]             best_val_q, best_val_d;
    logic [IDX_W-1:0]                  best_idx_q, best_idx_d;
    logic [IDX_W-1:0]                  class_q, class_d;
    logic [DATA_WIDTH-1:0]             max_q, max_d;
    logic                              done_q, done_d;

    logic [DATA_WIDTH-1:0]             cand;
    logic                              cand_gt;

    // Single element mux driven by the scan counter.
    always_comb begin
        cand = vec_q[0 +: DATA_WIDTH];
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cand = vec_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    fp32_greater u_cmp (
        .a  (cand),
        .b  (best_val_q),
        .gt (cand_gt)
    );

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        idx_d      = idx_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        class_d    = class_q;
        max_d      = max_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    vec_d      = data_i;
                    best_val_d = data_i[DATA_WIDTH-1:0];
                    best_idx_d = '0;
                    idx_d      = IDX_W'(1);
                    if (NUM_CLASSES == 1) begin
                        // Single class: the only element is the answer, no scan needed.
                        class_d = '0;
                        max_d   = data_i[DATA_WIDTH-1:0];
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                // Strictly-greater replacement keeps the lowest index on ties.
                if (cand_gt) begin
                    best_val_d = cand;
                    best_idx_d = idx_q;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // Publish including the last element's compare outcome.
                    class_d = cand_gt ? idx_q : best_idx_q;
                    max_d   = cand_gt ? cand : best_val_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            idx_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            class_q    <= '0;
            max_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            idx_q      <= idx_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            class_q    <= class_d;
            max_q      <= max_d;
            done_q     <= done_d;
        end
    end

    assign busy_o  = (state_q == ST_SCAN);
    assign done_o  = done_q;
    assign class_o = class_q;
    assign max_o   = max_q;

endmodule
